// File: rtl/spi_transaction_controller_if.sv
// Strobe/control bundle between the SPI transaction sequencer and the SPI
// memory datapath (input conditioners, shift register, address latch, memory).
interface spi_transaction_controller_if;
    logic       sclk_pe;
    logic       sclk_ne;
    logic       cs;
    logic       sr_bit0;
    logic       addr_we;
    logic       addr_inc;
    logic       dm_we;
    logic       sr_we;
    logic       miso_en;
    logic       busy;
    logic [3:0] state;

    // sequencer side: consumes edge strobes / CS, issues datapath strobes
    modport master (
        input  sclk_pe, sclk_ne, cs, sr_bit0,
        output addr_we, addr_inc, dm_we, sr_we, miso_en, busy, state
    );

    // datapath side: produces edge strobes / CS, consumes strobes
    modport slave (
        output sclk_pe, sclk_ne, cs, sr_bit0,
        input  addr_we, addr_inc, dm_we, sr_we, miso_en, busy, state
    );
endinterface

// File: rtl/spi_transaction_controller.sv
// SPI memory transaction sequencer. Counts SCLK rising edges, decodes the
// R/W flag from the header byte and issues single-clk strobes to the address
// latch, data memory and shift register. Optional burst with auto-increment.
module spi_transaction_controller #(
    parameter int DATA_WIDTH = 8,
    parameter bit BURST_EN   = 1'b1
) (
    input logic clk,
    input logic reset,
    spi_transaction_controller_if.master bus
);

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        GET_ADDR     = 4'd1,
        GOT_ADDR     = 4'd2,
        READ_WAIT    = 4'd3,
        READ_LOAD    = 4'd4,
        READ_SHIFT   = 4'd5,
        READ_NEXT    = 4'd6,
        WRITE_SHIFT  = 4'd7,
        WRITE_COMMIT = 4'd8,
        DONE         = 4'd9
    } state_t;

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    state_t        st, nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic addr_we_q, addr_inc_q, dm_we_q, sr_we_q, miso_en_q, busy_q;

    // Next-state and bit-counter logic; CS release overrides everything,
    // including a coincident SCLK edge.
    always_comb begin
        nxt     = st;
        cnt_nxt = cnt;
        if (st != IDLE && bus.cs) begin
            nxt     = IDLE;
            cnt_nxt = '0;
        end else begin
            case (st)
                IDLE: begin
                    if (!bus.cs) begin
                        nxt     = GET_ADDR;
                        cnt_nxt = '0;
                    end
                end
                GET_ADDR: begin
                    if (bus.sclk_pe) begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == LAST) begin
                            nxt     = GOT_ADDR;
                            cnt_nxt = '0;
                        end
                    end
                end
                // shift register already holds the final header bit here
                GOT_ADDR: begin
                    nxt     = bus.sr_bit0 ? READ_WAIT : WRITE_SHIFT;
                    cnt_nxt = '0;
                end
                // one clk for the latched address to reach memory
                READ_WAIT: nxt = READ_LOAD;
                READ_LOAD: begin
                    nxt     = READ_SHIFT;
                    cnt_nxt = '0;
                end
                READ_SHIFT: begin
                    if (bus.sclk_pe) begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == LAST) begin
                            nxt     = BURST_EN ? READ_NEXT : DONE;
                            cnt_nxt = '0;
                        end
                    end
                end
                READ_NEXT: nxt = READ_WAIT;
                WRITE_SHIFT: begin
                    if (bus.sclk_pe) begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == LAST) begin
                            nxt     = WRITE_COMMIT;
                            cnt_nxt = '0;
                        end
                    end
                end
                WRITE_COMMIT: begin
                    nxt     = BURST_EN ? WRITE_SHIFT : DONE;
                    cnt_nxt = '0;
                end
                DONE: nxt = DONE;
                default: begin
                    nxt     = IDLE;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // State/counter registers; outputs are registered from the next state so
    // they line up with the state register and never see an input directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            cnt        <= '0;
            addr_we_q  <= 1'b0;
            addr_inc_q <= 1'b0;
            dm_we_q    <= 1'b0;
            sr_we_q    <= 1'b0;
            miso_en_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            st         <= nxt;
            cnt        <= cnt_nxt;
            addr_we_q  <= (nxt == GOT_ADDR);
            addr_inc_q <= (nxt == READ_NEXT) || (BURST_EN && nxt == WRITE_COMMIT);
            dm_we_q    <= (nxt == WRITE_COMMIT);
            sr_we_q    <= (nxt == READ_LOAD);
            miso_en_q  <= (nxt == READ_SHIFT) || (nxt == READ_NEXT);
            busy_q     <= (nxt != IDLE);
        end
    end

    assign bus.state    = st;
    assign bus.addr_we  = addr_we_q;
    assign bus.addr_inc = addr_inc_q;
    assign bus.dm_we    = dm_we_q;
    assign bus.sr_we    = sr_we_q;
    assign bus.miso_en  = miso_en_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_transaction_controller.sv
// Randomized bench: a transaction script generates SPI traffic and, from the
// protocol rules, the state each clk must show; outputs follow from a table.
module tb_spi_transaction_controller;

    localparam logic [3:0] S_IDLE = 4'd0, S_GET = 4'd1, S_GOT = 4'd2,
                           S_RWAIT = 4'd3, S_RLOAD = 4'd4, S_RSHIFT = 4'd5,
                           S_RNEXT = 4'd6, S_WSHIFT = 4'd7, S_WCOMMIT = 4'd8,
                           S_DONE = 4'd9;

    logic clk = 1'b0;
    logic reset;

    spi_transaction_controller_if ifc0 ();
    spi_transaction_controller_if ifc1 ();

    spi_transaction_controller #(.DATA_WIDTH(8), .BURST_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(ifc0));
    spi_transaction_controller #(.DATA_WIDTH(8), .BURST_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(ifc1));

    always #5 clk = ~clk;

    int  vectors = 0;
    int  miscompares = 0;
    bit  mode;          // 0: check non-burst DUT, 1: check burst DUT
    bit  aborted;
    int  edges_done;
    int  abort_at;
    bit  coll;
    bit  inj;
    bit  rw_lock;
    bit  rw;

    logic [9:0] o0, o1;
    assign o0 = {ifc0.state, ifc0.busy, ifc0.addr_we, ifc0.addr_inc,
                 ifc0.dm_we, ifc0.sr_we, ifc0.miso_en};
    assign o1 = {ifc1.state, ifc1.busy, ifc1.addr_we, ifc1.addr_inc,
                 ifc1.dm_we, ifc1.sr_we, ifc1.miso_en};

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Expected {state, busy, addr_we, addr_inc, dm_we, sr_we, miso_en}
    function automatic logic [9:0] exp_out(input logic [3:0] st, input bit burst);
        logic [5:0] f;
        case (st)
            S_IDLE:    f = 6'b000000;
            S_GOT:     f = 6'b110000;
            S_RLOAD:   f = 6'b100010;
            S_RSHIFT:  f = 6'b100001;
            S_RNEXT:   f = 6'b101001;
            S_WCOMMIT: f = burst ? 6'b101100 : 6'b100100;
            default:   f = 6'b100000;
        endcase
        return {st, f};
    endfunction

    task automatic drive(input bit cs_v, input bit pe_v);
        logic b0, ne;
        b0 = rw_lock ? rw : 1'($urandom);
        ne = pe_v ? 1'b0 : 1'($urandom);
        ifc0.cs = cs_v; ifc0.sclk_pe = pe_v; ifc0.sclk_ne = ne; ifc0.sr_bit0 = b0;
        ifc1.cs = cs_v; ifc1.sclk_pe = pe_v; ifc1.sclk_ne = ne; ifc1.sr_bit0 = b0;
    endtask

    // One clk: apply inputs, then check the state the rules say must result.
    task automatic cyc(input bit cs_v, input bit pe_v, input logic [3:0] es);
        if (aborted) return;
        drive(cs_v, pe_v);
        @(posedge clk);
        #1;
        chk("cyc", mode ? o1 : o0, exp_out(es, mode));
    endtask

    // A single-clk state; optionally throw in an SCLK edge that must be ignored.
    task automatic tcyc(input logic [3:0] es);
        cyc(1'b0, inj & 1'($urandom), es);
    endtask

    // Gap cycles then one SCLK rising edge (or a CS release in its place).
    task automatic sclk_edge(input logic [3:0] es_gap, input logic [3:0] es_edge, input bit first);
        int unsigned ngap;
        if (aborted) return;
        if (edges_done + 1 == abort_at) begin
            cyc(1'b1, coll, S_IDLE);
            aborted = 1'b1;
            return;
        end
        ngap = first ? $urandom_range(6, 4) : $urandom_range(3, 1);
        repeat (ngap) cyc(1'b0, 1'b0, es_gap);
        cyc(1'b0, 1'b1, es_edge);
        edges_done++;
    endtask

    task automatic do_txn(input int nbytes, input bit rw_i, input int abort_i,
                          input bit coll_i, input bit inj_i);
        logic [3:0] fin;
        aborted = 1'b0; edges_done = 0; abort_at = abort_i;
        coll = coll_i; inj = inj_i; rw = rw_i; rw_lock = 1'b0;
        cyc(1'b1, 1'b0, S_IDLE);
        cyc(1'b0, 1'b0, S_GET);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) rw_lock = 1'b1;
            sclk_edge(S_GET, (i == 8) ? S_GOT : S_GET, 1'b0);
        end
        if (rw) begin
            for (int b = 0; b < nbytes; b++) begin
                tcyc(S_RWAIT); tcyc(S_RLOAD); tcyc(S_RSHIFT);
                for (int i = 1; i <= 8; i++)
                    sclk_edge(S_RSHIFT, (i < 8) ? S_RSHIFT : (mode ? S_RNEXT : S_DONE), i == 1);
            end
            if (mode) begin
                tcyc(S_RWAIT); tcyc(S_RLOAD); tcyc(S_RSHIFT);
                fin = S_RSHIFT;
            end else fin = S_DONE;
        end else begin
            tcyc(S_WSHIFT);
            for (int b = 0; b < nbytes; b++) begin
                for (int i = 1; i <= 8; i++)
                    sclk_edge(S_WSHIFT, (i < 8) ? S_WSHIFT : S_WCOMMIT, i == 1);
                tcyc(mode ? S_WSHIFT : S_DONE);
            end
            fin = mode ? S_WSHIFT : S_DONE;
        end
        repeat ($urandom_range(3, 1)) cyc(1'b0, 1'b0, fin);
        cyc(1'b1, 1'b0, S_IDLE);
        aborted = 1'b0;
        rw_lock = 1'b0;
        cyc(1'b1, 1'b0, S_IDLE);
    endtask

    task automatic pulse_reset();
        drive(1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset0", o0, 10'h000);
        chk("reset1", o1, 10'h000);
        reset = 1'b0;
    endtask

    task automatic random_phase(input int n);
        int unsigned nb, tot, ab;
        for (int t = 0; t < n; t++) begin
            nb  = mode ? $urandom_range(3, 1) : 1;
            tot = 8 + 8 * nb;
            ab  = ($urandom_range(3, 0) == 0) ? $urandom_range(tot, 1) : 0;
            do_txn(int'(nb), 1'($urandom), int'(ab), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        mode = 1'b0; aborted = 1'b0; rw_lock = 1'b0; rw = 1'b0;
        reset = 1'b1;
        drive(1'b1, 1'b0);
        #1;
        chk("reset_async0", o0, 10'h000);
        chk("reset_async1", o1, 10'h000);
        @(posedge clk); #1;
        reset = 1'b0;

        // non-burst: plain write, plain read, abort after 5th data edge,
        // collision with the 8th header edge, then random traffic
        mode = 1'b0;
        do_txn(1, 1'b0, 0, 1'b0, 1'b0);
        do_txn(1, 1'b1, 0, 1'b0, 1'b0);
        do_txn(1, 1'b0, 14, 1'b0, 1'b0);
        do_txn(1, 1'b0, 8, 1'b1, 1'b0);
        do_txn(1, 1'b1, 0, 1'b0, 1'b1);
        random_phase(40);

        // async reset landing mid READ_SHIFT, between clk edges
        aborted = 1'b0; edges_done = 0; abort_at = 0; inj = 1'b0; rw = 1'b1; rw_lock = 1'b0;
        cyc(1'b1, 1'b0, S_IDLE);
        cyc(1'b0, 1'b0, S_GET);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) rw_lock = 1'b1;
            sclk_edge(S_GET, (i == 8) ? S_GOT : S_GET, 1'b0);
        end
        tcyc(S_RWAIT); tcyc(S_RLOAD); tcyc(S_RSHIFT);
        sclk_edge(S_RSHIFT, S_RSHIFT, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid", o0, 10'h000);
        @(posedge clk); #1;
        chk("rst_hold", o0, 10'h000);
        rw_lock = 1'b0;
        drive(1'b1, 1'b0);
        reset = 1'b0;
        repeat (3) cyc(1'b1, 1'b0, S_IDLE);

        // burst: 3-byte write, 2-byte read, then random traffic
        pulse_reset();
        mode = 1'b1;
        do_txn(3, 1'b0, 0, 1'b0, 1'b0);
        do_txn(2, 1'b1, 0, 1'b0, 1'b0);
        do_txn(2, 1'b0, 20, 1'b1, 1'b1);
        random_phase(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the script ever stalls.
    initial begin
        #900000;
        $display("FAIL timeout t=%0t got=running exp=finished", $time);
        $fatal(1, "timeout");
    end

endmodule
